// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receive and transmit paths.
//   DATA_W         : number of data bits per character
//   rx_state_t     : receiver frame FSM states
//   clks_per_tick  : system clocks per oversampling tick (integer division)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    // Truncating division: the bit period runs slightly short of nominal,
    // which keeps mid-bit sampling inside the bit for the default rates.
    function automatic int clks_per_tick(input int clk_freq, input int baud,
                                         input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_os_tick
// Oversampling tick generator. A free-running counter 0..CLKS_PER_TICK-1
// produces a single-clock tick on its wrap cycle. Asserting restart returns
// the counter to 0 so the tick phase can be aligned to an incoming frame.
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   restart : synchronous counter restart (suppresses the tick that cycle)
//   tick    : 1-clk clock-enable pulse, once every CLKS_PER_TICK clocks
// -----------------------------------------------------------------------------
module uart_os_tick #(
    parameter int CLKS_PER_TICK = 54
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_TICK - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (restart || (cnt_reg == CNT_LAST)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == CNT_LAST) && !restart;

endmodule

// File: rtl/uart_os_receiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_os_receiver
// Oversampling UART receiver (8 data bits, LSB first, 1 stop bit) for the GPS
// serial link. Each bit is resolved by a 3-sample majority vote around
// mid-bit; received bytes are offered on a valid/ready handshake together with
// per-byte framing and parity error flags.
//
// Build option: define UART_RX_PARITY_EN to expect a parity bit between the
// data and stop bits (even parity, or odd when PARITY_ODD = 1). Without it the
// framing is 8N1 and rx_parity_err is constant 0.
//
// Ports:
//   clk           : system clock
//   rst_n         : asynchronous active-low reset
//   rx_in         : asynchronous serial line, idle high
//   rx_data       : received byte
//   rx_valid      : rx_data and error flags valid
//   rx_ready      : consumer accepts the byte
//   rx_frame_err  : stop bit sampled low for this byte
//   rx_parity_err : parity mismatch for this byte
//   rx_overrun    : sticky, a byte was dropped; cleared by the next handshake
//   rx_busy       : frame reception in progress (FSM not idle)
// -----------------------------------------------------------------------------
module uart_os_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_frame_err,
    output logic              rx_parity_err,
    output logic              rx_overrun,
    output logic              rx_busy
);

    localparam int CLKS_PER_TICK = clks_per_tick(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SC_W          = $clog2(OVERSAMPLE);
    localparam int MID           = OVERSAMPLE / 2;
    localparam int BIT_CNT_W     = $clog2(DATA_W);
    localparam int SYNC_STAGES   = 2;

    localparam logic [SC_W-1:0]      SC_SAMP0 = SC_W'(MID - 1);
    localparam logic [SC_W-1:0]      SC_SAMP1 = SC_W'(MID);
    localparam logic [SC_W-1:0]      SC_DEC   = SC_W'(MID + 1);
    localparam logic [SC_W-1:0]      SC_LAST  = SC_W'(OVERSAMPLE - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_W - 1);

    rx_state_t state_reg, state_next;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rxs;
    logic                   rxs_prev_reg;
    logic                   tick;
    logic                   tick_restart;
    logic [SC_W-1:0]        sc_reg;
    logic [1:0]             samp_reg;
    logic                   decide;
    logic                   bit_val;
    logic [DATA_W-1:0]      shift_reg;
    logic [BIT_CNT_W-1:0]   bit_cnt_reg;
    logic                   load_out;
    logic                   perr_reg;

    logic [DATA_W-1:0]      data_out_reg;
    logic                   valid_out_reg;
    logic                   ferr_out_reg;
    logic                   perr_out_reg;
    logic                   ovr_out_reg;

    // -------------------------------------------------------------------------
    // Tick generator, re-phased on every detected start edge
    // -------------------------------------------------------------------------
    uart_os_tick #(
        .CLKS_PER_TICK (CLKS_PER_TICK)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (tick_restart),
        .tick    (tick)
    );

    assign rxs = sync_reg[SYNC_STAGES-1];

    // The third vote is the live synchronized value at the decision tick.
    assign decide  = tick && (sc_reg == SC_DEC);
    assign bit_val = (samp_reg[0] & samp_reg[1]) |
                     (samp_reg[0] & rxs) |
                     (samp_reg[1] & rxs);

    // -------------------------------------------------------------------------
    // Frame FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        tick_restart = 1'b0;
        load_out     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (rxs_prev_reg && !rxs) begin
                    state_next   = ST_START;
                    tick_restart = 1'b1;
                end
            end
            ST_START: begin
                // A high majority means the edge was a glitch.
                if (decide) begin
                    state_next = bit_val ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (decide && (bit_cnt_reg == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
            ST_PARITY: begin
                if (decide) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is seen.
                if (decide) begin
                    load_out   = 1'b1;
                    state_next = bit_val ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                // Suppresses repeated 0x00 bytes while a break holds the line.
                if (rxs) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Input synchronizer, sample counter and data shift register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg     <= '1;
            rxs_prev_reg <= 1'b1;
            sc_reg       <= '0;
            samp_reg     <= 2'b11;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
        end else begin
            sync_reg     <= {sync_reg[SYNC_STAGES-2:0], rx_in};
            rxs_prev_reg <= rxs;

            if (tick_restart) begin
                sc_reg <= '0;
            end else if (tick) begin
                sc_reg <= (sc_reg == SC_LAST) ? '0 : sc_reg + 1'b1;
                if (sc_reg == SC_SAMP0) begin
                    samp_reg[0] <= rxs;
                end
                if (sc_reg == SC_SAMP1) begin
                    samp_reg[1] <= rxs;
                end
            end

            if (decide && (state_reg == ST_START)) begin
                bit_cnt_reg <= '0;
            end else if (decide && (state_reg == ST_DATA)) begin
                shift_reg   <= {bit_val, shift_reg[DATA_W-1:1]};
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Parity check
    // -------------------------------------------------------------------------
`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_reg <= 1'b0;
        end else if (decide && (state_reg == ST_START)) begin
            perr_reg <= 1'b0;
        end else if (decide && (state_reg == ST_PARITY)) begin
            // Mismatch when the received bit differs from ^data ^ PARITY_ODD.
            perr_reg <= bit_val ^ (^shift_reg) ^ PARITY_ODD[0];
        end
    end
`else
    // No parity bit on the line: the flag is constant 0 for every byte.
    assign perr_reg = 1'b0 & PARITY_ODD[0];
`endif

    // -------------------------------------------------------------------------
    // Output holding register with overrun detection
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_reg  <= '0;
            valid_out_reg <= 1'b0;
            ferr_out_reg  <= 1'b0;
            perr_out_reg  <= 1'b0;
            ovr_out_reg   <= 1'b0;
        end else if (load_out) begin
            if (!valid_out_reg || rx_ready) begin
                // Register is empty or draining this cycle: take the new byte.
                data_out_reg  <= shift_reg;
                valid_out_reg <= 1'b1;
                ferr_out_reg  <= !bit_val;
                perr_out_reg  <= perr_reg;
                if (valid_out_reg) begin
                    ovr_out_reg <= 1'b0;
                end
            end else begin
                // Held byte not yet taken: drop the new one.
                ovr_out_reg <= 1'b1;
            end
        end else if (valid_out_reg && rx_ready) begin
            valid_out_reg <= 1'b0;
            ovr_out_reg   <= 1'b0;
        end
    end

    assign rx_data       = data_out_reg;
    assign rx_valid      = valid_out_reg;
    assign rx_frame_err  = ferr_out_reg;
    assign rx_parity_err = perr_out_reg;
    assign rx_overrun    = ovr_out_reg;
    assign rx_busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_os_receiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_os_receiver
// Directed frames driven onto rx_in; expected bytes are queued as each frame
// is issued and a negedge monitor pops and compares on every handshake.
// Line rate is 230400 baud at 100 MHz: 27 clk per tick, 432 clk per bit.
// -----------------------------------------------------------------------------
module tb_uart_os_receiver;

    localparam int BIT_CLKS = 27 * 16;

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
        logic       ovr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_overrun;
    logic       rx_busy;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    uart_os_receiver #(
        .CLK_FREQ   (100000000),
        .BAUD       (230400),
        .OVERSAMPLE (16),
        .PARITY_ODD (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_in         (rx_in),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_overrun    (rx_overrun),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    // Inputs change 2 ns after a rising edge; outputs are read then or on
    // the falling edge.
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end else begin
            $display("ok   %s = %0h", name, got);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(1'b1);
    endtask
`endif

    // Scoreboard monitor: one line per completed handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rx_valid && rx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte got data=%h fe=%b pe=%b ovr=%b exp=none",
                         rx_data, rx_frame_err, rx_parity_err, rx_overrun);
            end else begin
                e = exp_q.pop_front();
                if ({rx_data, rx_frame_err, rx_parity_err, rx_overrun} !== e) begin
                    errors++;
                    $display("FAIL rx_byte got data=%h fe=%b pe=%b ovr=%b exp data=%h fe=%b pe=%b ovr=%b",
                             rx_data, rx_frame_err, rx_parity_err, rx_overrun,
                             e.data, e.fe, e.pe, e.ovr);
                end else begin
                    $display("RX   data=%h fe=%b pe=%b ovr=%b", rx_data,
                             rx_frame_err, rx_parity_err, rx_overrun);
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        rx_in    = 1'b1;
        rx_ready = 1'b0;
        wait_clks(4);
        chk("reset_valid", rx_valid, 0);
        chk("reset_data", rx_data, 0);
        chk("reset_ferr", rx_frame_err, 0);
        chk("reset_perr", rx_parity_err, 0);
        chk("reset_ovr", rx_overrun, 0);
        chk("reset_busy", rx_busy, 0);
        rst_n = 1'b1;
        wait_clks(20);

        // Single clean frame, consumer always ready.
        rx_ready = 1'b1;
        exp_q.push_back('{data: 8'hA5, fe: 1'b0, pe: 1'b0, ovr: 1'b0});
        send_frame(8'hA5, 1'b1);
        wait_clks(BIT_CLKS);
        chk("a5_drained", exp_q.size(), 0);

        // 300 ns glitch: start detected, rejected at mid-bit.
        rx_in = 1'b0;
        wait_clks(20);
        chk("glitch_busy", rx_busy, 1);
        wait_clks(10);
        rx_in = 1'b1;
        wait_clks(BIT_CLKS);
        chk("glitch_idle", rx_busy, 0);

        // Back-to-back frames with consumer stalled: second byte dropped.
        rx_ready = 1'b0;
        exp_q.push_back('{data: 8'h31, fe: 1'b0, pe: 1'b0, ovr: 1'b1});
        send_frame(8'h31, 1'b1);
        send_frame(8'h0D, 1'b1);
        wait_clks(BIT_CLKS);
        chk("ovr_valid_held", rx_valid, 1);
        chk("ovr_data_held", rx_data, 8'h31);
        chk("ovr_flag_set", rx_overrun, 1);
        rx_ready = 1'b1;
        wait_clks(2);
        chk("ovr_valid_clear", rx_valid, 0);
        chk("ovr_flag_clear", rx_overrun, 0);
        chk("ovr_drained", exp_q.size(), 0);

        // Stop bit low then break for three frame times: one byte only.
        exp_q.push_back('{data: 8'h55, fe: 1'b1, pe: 1'b0, ovr: 1'b0});
        send_frame(8'h55, 1'b0);
        wait_clks(30 * BIT_CLKS);
        chk("break_busy", rx_busy, 1);
        rx_in = 1'b1;
        wait_clks(2 * BIT_CLKS);
        chk("break_idle", rx_busy, 0);
        chk("break_drained", exp_q.size(), 0);

        // Reset during data bit 4 of 0xF8; the line stays high afterwards
        // so no fresh falling edge exists for the rest of that frame.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(((8'hF8 >> i) & 8'h01) != 0);
        rx_in = 1'b1;
        wait_clks(100);
        rst_n = 1'b0;
        wait_clks(20);
        chk("midrst_busy", rx_busy, 0);
        chk("midrst_valid", rx_valid, 0);
        rst_n = 1'b1;
        wait_clks(BIT_CLKS * 7);
        chk("midrst_idle", rx_busy, 0);
        exp_q.push_back('{data: 8'h42, fe: 1'b0, pe: 1'b0, ovr: 1'b0});
        send_frame(8'h42, 1'b1);
        wait_clks(BIT_CLKS);
        chk("midrst_drained", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the correct parity bit is 1.
        exp_q.push_back('{data: 8'h07, fe: 1'b0, pe: 1'b1, ovr: 1'b0});
        send_frame_par(8'h07, 1'b0);
        exp_q.push_back('{data: 8'h07, fe: 1'b0, pe: 1'b0, ovr: 1'b0});
        send_frame_par(8'h07, 1'b1);
        wait_clks(BIT_CLKS);
        chk("parity_drained", exp_q.size(), 0);
`endif

        wait_clks(BIT_CLKS);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_valid", rx_valid, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
